keypad_scanner: RTL

Scans a 4x4 matrix keypad, synchronizes and debounces the row inputs, and produces one 4-bit key code per accepted press. It sits directly upstream of the BCD-to-seven-segment decoder: `bcd_out` feeds the decoder's 4-bit input. Codes 0-9 are digits, 10 is '.', 11 is 'U', and 12-15 are letter keys or blank, which the decoder shows as all segments off.

---
 rtl/keypad_scanner.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: synchronizes the active-low rows, steps one low column at a time,
// debounces press and release, and emits one latched 4-bit key code per accepted press.
module keypad_scanner #(
  parameter int SCAN_DIV   = 50000,
  parameter int DEB_FRAMES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] row_in,
  output logic [3:0] col_out,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held,
  output logic [3:0] bcd_out
);

  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CW = $clog2(DEB_FRAMES + 1);
  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] CNT_DONE   = CW'(DEB_FRAMES);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DEBOUNCE,
    S_HELD
  } state_e;

  state_e        state_q, state_d;
  logic [3:0]    row_meta_q, row_s_q;
  logic [DW-1:0] dwell_q;
  logic [1:0]    col_idx_q, col_idx_d;
  logic [1:0]    cand_row_q, cand_row_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] cnt_inc;
  logic [3:0]    col_out_q, key_code_q, key_code_d, bcd_q, bcd_d;
  logic          key_valid_q, key_valid_d, key_held_q, key_held_d;
  logic          tick, hit;
  logic [1:0]    hit_row;

  function automatic logic [3:0] map_key(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] code;
    case ({r, c})
      4'b00_00: code = 4'd1;
      4'b00_01: code = 4'd2;
      4'b00_10: code = 4'd3;
      4'b00_11: code = 4'd12;
      4'b01_00: code = 4'd4;
      4'b01_01: code = 4'd5;
      4'b01_10: code = 4'd6;
      4'b01_11: code = 4'd13;
      4'b10_00: code = 4'd7;
      4'b10_01: code = 4'd8;
      4'b10_10: code = 4'd9;
      4'b10_11: code = 4'd14;
      4'b11_00: code = 4'd10;
      4'b11_01: code = 4'd0;
      4'b11_10: code = 4'd11;
      default:  code = 4'd15;
    endcase
    return code;
  endfunction

  // Two-flop synchronizer: row_in is asynchronous to clk.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_meta_q <= 4'b1111;
      row_s_q    <= 4'b1111;
    end else begin
      row_meta_q <= row_in;
      row_s_q    <= row_meta_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) dwell_q <= '0;
    else        dwell_q <= tick ? '0 : dwell_q + DW'(1);
  end

  assign tick    = (dwell_q == DWELL_LAST);
  assign hit     = ~&row_s_q;
  assign cnt_inc = cnt_q + CW'(1);

  // Lowest-index low row wins when several rows in one column are down.
  always_comb begin
    casez (row_s_q)
      4'b???0: hit_row = 2'd0;
      4'b??01: hit_row = 2'd1;
      4'b?011: hit_row = 2'd2;
      default: hit_row = 2'd3;
    endcase
  end

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d     = state_q;
    col_idx_d   = col_idx_q;
    cand_row_d  = cand_row_q;
    cnt_d       = cnt_q;
    key_code_d  = key_code_q;
    bcd_d       = bcd_q;
    key_valid_d = 1'b0;
    key_held_d  = key_held_q;
    if (tick) begin
      unique case (state_q)
        S_IDLE: begin
          if (hit) begin
            cand_row_d = hit_row;
            cnt_d      = CW'(1);
            state_d    = S_DEBOUNCE;
          end else begin
            col_idx_d = col_idx_q + 2'd1;
          end
        end
        S_DEBOUNCE: begin
          if (hit && (hit_row == cand_row_q)) begin
            if (cnt_inc == CNT_DONE) begin
              key_code_d  = map_key(cand_row_q, col_idx_q);
              bcd_d       = map_key(cand_row_q, col_idx_q);
              key_valid_d = 1'b1;
              key_held_d  = 1'b1;
              cnt_d       = '0;
              state_d     = S_HELD;
            end else begin
              cnt_d = cnt_inc;
            end
          end else begin
            cnt_d     = '0;
            col_idx_d = col_idx_q + 2'd1;
            state_d   = S_IDLE;
          end
        end
        S_HELD: begin
          // Only the candidate row matters; other rows in this column are ignored.
          if (row_s_q[cand_row_q]) begin
            if (cnt_inc == CNT_DONE) begin
              key_held_d = 1'b0;
              cnt_d      = '0;
              col_idx_d  = col_idx_q + 2'd1;
              state_d    = S_IDLE;
            end else begin
              cnt_d = cnt_inc;
            end
          end else begin
            cnt_d = '0;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      col_idx_q   <= 2'd0;
      cand_row_q  <= 2'd0;
      cnt_q       <= '0;
      col_out_q   <= 4'b1110;
      key_code_q  <= 4'd0;
      bcd_q       <= 4'b1111;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      col_idx_q   <= col_idx_d;
      cand_row_q  <= cand_row_d;
      cnt_q       <= cnt_d;
      col_out_q   <= ~(4'b0001 << col_idx_d);
      key_code_q  <= key_code_d;
      bcd_q       <= bcd_d;
      key_valid_q <= key_valid_d;
      key_held_q  <= key_held_d;
    end
  end

  assign col_out   = col_out_q;
  assign key_code  = key_code_q;
  assign bcd_out   = bcd_q;
  assign key_valid = key_valid_q;
  assign key_held  = key_held_q;

endmodule
